// File: rtl/alu_pipe_pkg.sv
// Shared opcode encodings and the N/Z/V flag bundle for the alu_pipe datapath.
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_NOR = 3'b011,
        OP_SLL = 3'b100,
        OP_SRL = 3'b101,
        OP_LHB = 3'b110,
        OP_SRA = 3'b111
    } op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
    } flags_t;

    // Only add/sub drive N and V; every other op leaves them alone.
    function automatic logic is_arith(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU: op/operands/shamt -> result and signed overflow.
// Define ALU_PIPE_SAT_EN to clamp overflowing add/sub results instead of wrapping.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src0,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;

    assign sum  = src1 + src0;
    assign diff = src1 - src0;

    // The true result of an overflowing add/sub always carries src1's sign.
    assign add_ovf = (src1[WIDTH-1] == src0[WIDTH-1]) && (sum[WIDTH-1]  != src1[WIDTH-1]);
    assign sub_ovf = (src1[WIDTH-1] != src0[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]);

`ifdef ALU_PIPE_SAT_EN
    logic [WIDTH-1:0] sat_val;
    assign sat_val = src1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                ovf = add_ovf;
`ifdef ALU_PIPE_SAT_EN
                result = add_ovf ? sat_val : sum;
`else
                result = sum;
`endif
            end
            OP_SUB: begin
                ovf = sub_ovf;
`ifdef ALU_PIPE_SAT_EN
                result = sub_ovf ? sat_val : diff;
`else
                result = diff;
`endif
            end
            OP_AND: result = src1 & src0;
            OP_NOR: result = ~(src1 | src0);
            OP_SLL: result = src1 << shamt;
            OP_SRL: result = src1 >> shamt;
            OP_SRA: result = $signed(src1) >>> shamt;
            OP_LHB: result = {src1[WIDTH/2-1:0], src0[WIDTH/2-1:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds the operation, S2 holds dst and N/Z/V.
// Build option ALU_PIPE_SAT_EN (saturating add/sub) is handled inside alu_pipe_core.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src0,
    input  logic [SHW-1:0]   shamt,
    input  logic             flag_hold,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dst,
    output logic             N,
    output logic             Z,
    output logic             V
);

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q,    s1_op_d;
    logic [WIDTH-1:0] s1_src1_q,  s1_src1_d;
    logic [WIDTH-1:0] s1_src0_q,  s1_src0_d;
    logic [SHW-1:0]   s1_shamt_q, s1_shamt_d;
    logic             s1_hold_q,  s1_hold_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] dst_q,       dst_d;
    flags_t           flags_q,     flags_d;

    logic             s2_adv;
    logic             s2_load;
    logic             accept;
    logic [WIDTH-1:0] core_result;
    logic             core_ovf;

    alu_pipe_core #(
        .WIDTH(WIDTH),
        .SHW  (SHW)
    ) u_core (
        .op    (s1_op_q),
        .src1  (s1_src1_q),
        .src0  (s1_src0_q),
        .shamt (s1_shamt_q),
        .result(core_result),
        .ovf   (core_ovf)
    );

    // S2 may take a new value whenever it is empty or being drained this edge.
    assign s2_adv   = ~out_valid_q | out_ready;
    assign s2_load  = s2_adv & s1_valid_q;
    assign in_ready = ~rst & (~s1_valid_q | s2_adv);
    assign accept   = in_valid & in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_src1_d  = s1_src1_q;
        s1_src0_d  = s1_src0_q;
        s1_shamt_d = s1_shamt_q;
        s1_hold_d  = s1_hold_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = op;
            s1_src1_d  = src1;
            s1_src0_d  = src0;
            s1_shamt_d = shamt;
            s1_hold_d  = flag_hold;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
        dst_d       = s2_load ? core_result : dst_q;
        flags_d     = flags_q;
        if (s2_load && !s1_hold_q) begin
            flags_d.z = (core_result == '0);
            if (is_arith(op_e'(s1_op_q))) begin
                flags_d.n = core_result[WIDTH-1];
                flags_d.v = core_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_src1_q   <= '0;
            s1_src0_q   <= '0;
            s1_shamt_q  <= '0;
            s1_hold_q   <= 1'b0;
            out_valid_q <= 1'b0;
            dst_q       <= '0;
            flags_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_src1_q   <= s1_src1_d;
            s1_src0_q   <= s1_src0_d;
            s1_shamt_q  <= s1_shamt_d;
            s1_hold_q   <= s1_hold_d;
            out_valid_q <= out_valid_d;
            dst_q       <= dst_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dst       = dst_q;
    assign N         = flags_q.n;
    assign Z         = flags_q.z;
    assign V         = flags_q.v;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=16): vector table plus scoreboarded corner sequences.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

`ifdef ALU_PIPE_SAT_EN
    localparam logic [15:0] EXP_ADD_OVF   = 16'h7FFF;
    localparam logic [15:0] EXP_SUB_OVF   = 16'h8000;
    localparam logic        EXP_ADD_OVF_N = 1'b0;
`else
    localparam logic [15:0] EXP_ADD_OVF   = 16'h8000;
    localparam logic [15:0] EXP_SUB_OVF   = 16'h7FFF;
    localparam logic        EXP_ADD_OVF_N = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] src1;
    logic [15:0] src0;
    logic [3:0]  shamt;
    logic        flag_hold;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dst;
    logic        N, Z, V;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .src1     (src1),
        .src0     (src0),
        .shamt    (shamt),
        .flag_hold(flag_hold),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dst      (dst),
        .N        (N),
        .Z        (Z),
        .V        (V)
    );

    typedef struct {
        logic [15:0] dst;
        logic        n;
        logic        z;
        logic        v;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  sh;
        logic        hold;
        logic [15:0] exp_dst;
    } vec_t;

    exp_t        sbq[$];
    vec_t        vt[12];
    int          errors = 0;
    int          checks = 0;
    int          n_pop  = 0;
    bit          accepted;
    logic [15:0] cur_exp;
    logic        m_n, m_z, m_v;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent overflow reference: 17-bit sign-extended arithmetic.
    function automatic logic ovf_of(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        logic signed [16:0] r;
        if (o == OP_ADD)      r = $signed({a[15], a}) + $signed({b[15], b});
        else if (o == OP_SUB) r = $signed({a[15], a}) - $signed({b[15], b});
        else                  return 1'b0;
        return r[16] != r[15];
    endfunction

    // One clock: sample handshakes on the falling edge, return 1 time unit after the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        accepted = in_valid && in_ready;
        if (accepted) begin
            if (!flag_hold) begin
                m_z = (cur_exp == 16'h0000);
                if (op == OP_ADD || op == OP_SUB) begin
                    m_n = cur_exp[15];
                    m_v = ovf_of(op, src1, src0);
                end
            end
            e.dst = cur_exp;
            e.n   = m_n;
            e.z   = m_z;
            e.v   = m_v;
            sbq.push_back(e);
            $display("issue  op=%0d src1=%h src0=%h shamt=%0d hold=%0b exp=%h",
                     op, src1, src0, shamt, flag_hold, cur_exp);
        end
        if (out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stale_result: got dst=%h expected no output", dst);
            end else begin
                chk("dst", dst, sbq[0].dst);
                chk("flags_nzv", 16'({N, Z, V}), 16'({sbq[0].n, sbq[0].z, sbq[0].v}));
                if (out_ready) begin
                    $display("result dst=%h N=%0b Z=%0b V=%0b", dst, N, Z, V);
                    void'(sbq.pop_front());
                    n_pop++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] sh, input logic hold, input logic [15:0] exp);
        bit ok = 1'b0;
        op = o; src1 = a; src0 = b; shamt = sh; flag_hold = hold;
        cur_exp  = exp;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (accepted) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=%0b expected acceptance within 20 cycles", in_ready);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        vt[0]  = '{OP_ADD, 16'h1234, 16'h1111, 4'd0, 1'b0, 16'h2345};
        vt[1]  = '{OP_SUB, 16'h0003, 16'h0005, 4'd0, 1'b0, 16'hFFFE};
        vt[2]  = '{OP_AND, 16'hF0F0, 16'h3C3C, 4'd0, 1'b0, 16'h3030};
        vt[3]  = '{OP_NOR, 16'hF0F0, 16'h0F00, 4'd0, 1'b0, 16'h000F};
        vt[4]  = '{OP_SLL, 16'h0001, 16'h0000, 4'd4, 1'b0, 16'h0010};
        vt[5]  = '{OP_SRL, 16'h8001, 16'h0000, 4'd1, 1'b0, 16'h4000};
        vt[6]  = '{OP_SRA, 16'h8001, 16'h0000, 4'd1, 1'b0, 16'hC000};
        vt[7]  = '{OP_LHB, 16'h12AB, 16'h34CD, 4'd0, 1'b0, 16'hABCD};
        vt[8]  = '{OP_ADD, 16'h7FFF, 16'h0001, 4'd0, 1'b0, EXP_ADD_OVF};
        vt[9]  = '{OP_SUB, 16'h8000, 16'h0001, 4'd0, 1'b0, EXP_SUB_OVF};
        vt[10] = '{OP_ADD, 16'hFFFF, 16'h0001, 4'd0, 1'b0, 16'h0000};
        vt[11] = '{OP_AND, 16'hFFFF, 16'h0F0F, 4'd0, 1'b1, 16'h0F0F};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; src1 = '0; src0 = '0; shamt = '0; flag_hold = 1'b0;
        cur_exp = '0; m_n = 1'b0; m_z = 1'b0; m_v = 1'b0;
        repeat (2) cycle();
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_dst", dst, 16'h0000);
        chk("rst_flags", 16'({N, Z, V}), 16'h0);
        chk("rst_in_ready", 16'(in_ready), 16'h0);
        rst = 1'b0;
        #1;
        chk("in_ready_idle", 16'(in_ready), 16'h1);

        // Table: back-to-back with consumer always ready.
        foreach (vt[i]) issue(vt[i].op, vt[i].a, vt[i].b, vt[i].sh, vt[i].hold, vt[i].exp_dst);
        repeat (3) cycle();

        // Add overflow with first-result latency.
        issue(OP_ADD, 16'h7FFF, 16'h0001, 4'd0, 1'b0, EXP_ADD_OVF);
        chk("latency_k", 16'(out_valid), 16'h0);
        cycle();
        chk("latency_k1", 16'(out_valid), 16'h1);
        chk("add_ovf_dst", dst, EXP_ADD_OVF);
        chk("add_ovf_v", 16'(V), 16'h1);
        chk("add_ovf_n", 16'(N), 16'(EXP_ADD_OVF_N));
        chk("add_ovf_z", 16'(Z), 16'h0);
        repeat (2) cycle();

        // Sub overflow then a zero result.
        issue(OP_SUB, 16'h8000, 16'h0001, 4'd0, 1'b0, EXP_SUB_OVF);
        issue(OP_SUB, 16'h0005, 16'h0005, 4'd0, 1'b0, 16'h0000);
        repeat (3) cycle();
        chk("sub_zero_nzv", 16'({N, Z, V}), 16'b010);

        // Shifts and lhb.
        issue(OP_SRA, 16'h8000, 16'h0000, 4'd15, 1'b0, 16'hFFFF);
        issue(OP_LHB, 16'h12AB, 16'h34CD, 4'd0, 1'b0, 16'hABCD);
        issue(OP_SRL, 16'h8000, 16'h0000, 4'd15, 1'b0, 16'h0001);
        repeat (3) cycle();
        chk("srl_z", 16'(Z), 16'h0);

        // Flag hold on a zero result.
        issue(OP_AND, 16'h00F0, 16'h0F00, 4'd0, 1'b1, 16'h0000);
        repeat (3) cycle();
        chk("hold_z", 16'(Z), 16'h0);

        // Stall: two accepted, third blocked, then drained one per cycle.
        out_ready = 1'b0;
        issue(OP_ADD, 16'h0001, 16'h0002, 4'd0, 1'b0, 16'h0003);
        issue(OP_SUB, 16'h000A, 16'h0003, 4'd0, 1'b0, 16'h0007);
        op = OP_AND; src1 = 16'hFFFF; src0 = 16'h00FF; shamt = '0; flag_hold = 1'b0;
        cur_exp = 16'h00FF; in_valid = 1'b1;
        #1;
        chk("stall_in_ready", 16'(in_ready), 16'h0);
        repeat (2) begin
            cycle();
            chk("stall_no_accept", 16'(accepted), 16'h0);
        end
        out_ready = 1'b1;
        p0 = n_pop;
        cycle();
        chk("stall_c_accept", 16'(accepted), 16'h1);
        in_valid = 1'b0;
        repeat (2) cycle();
        chk("drain_per_cycle", 16'(n_pop - p0), 16'd3);
        repeat (2) cycle();

        // Reset with two operations in flight.
        out_ready = 1'b0;
        issue(OP_ADD, 16'h4000, 16'h4000, 4'd0, 1'b0, EXP_ADD_OVF);
        issue(OP_NOR, 16'h0000, 16'h0000, 4'd0, 1'b0, 16'hFFFF);
        rst = 1'b1;
        op = OP_ADD; src1 = 16'h0001; src0 = 16'h0001; flag_hold = 1'b0;
        cur_exp = 16'h0002; in_valid = 1'b1;
        #1;
        chk("rst_in_ready_comb", 16'(in_ready), 16'h0);
        cycle();
        chk("midrst_out_valid", 16'(out_valid), 16'h0);
        chk("midrst_flags", 16'({N, Z, V}), 16'h0);
        chk("midrst_dst", dst, 16'h0000);
        sbq.delete();
        m_n = 1'b0; m_z = 1'b0; m_v = 1'b0;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) cycle();
        issue(OP_ADD, 16'h0001, 16'h0001, 4'd0, 1'b0, 16'h0002);
        repeat (3) cycle();
        chk("scoreboard_empty", 16'(sbq.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; legal values are even and at least 8.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operation presented.
REQ-006 in_ready  output  1  operation accepted this edge when in_valid&in_ready.
REQ-007 op  input  3  opcode: 000 add, 001 sub, 010 and, 011 nor, 100 sll, 101 srl, 111 sra, 110 lhb.
REQ-008 src1, src0  input  WIDTH  operands.
REQ-009 shamt  input  SHW  shift amount, unsigned.
REQ-010 flag_hold  input  1  this operation leaves N/Z/V unchanged.
REQ-011 out_valid  output  1  dst holds a result.
REQ-012 out_ready  input  1  consumer takes dst when out_valid&out_ready.
REQ-013 dst  output  WIDTH  registered result.
REQ-014 N, Z, V  output  1 each  registered flags.

Function
REQ-015 Two register stages: S1 captures op, operands, shamt and flag_hold; S2 holds dst and flags.
REQ-016 Latency: an operation accepted at edge k produces out_valid=1 with its dst from edge k+1 onward, assuming no stall.
REQ-017 Advance rules: S2 loads when S2 is empty or out_ready=1. in_ready equals ~s1_valid OR S2 loads. This sustains one operation per cycle with no bubbles.
REQ-018 Under stall, dst, out_valid and S1 contents hold. Results are never dropped, duplicated or reordered.
REQ-019 The output stage is valid/ready compliant: dst is stable while out_valid=1 and out_ready=0.
REQ-020 add is src1+src0 and sub is src1-src0, both two's complement over WIDTH bits.
REQ-021 Add overflow occurs when both operands have the same sign and the result sign differs from it.
REQ-022 Sub overflow occurs when the operand signs differ and the result sign differs from src1.
REQ-023 and is src1&src0; nor is ~(src1|src0).
REQ-024 Shifts: sll and srl shift src1 logically by shamt; sra shifts src1 arithmetically by shamt.
REQ-025 lhb result is {src1[WIDTH/2-1:0], src0[WIDTH/2-1:0]}.
REQ-026 Flags update on the edge S2 loads a result whose flag_hold=0:
  - Z is set from (dst==0) for all ops.
  - N is set from dst[WIDTH-1] and V from overflow for add/sub only.
  - For other ops, N and V retain their values.
REQ-027 flag_hold=1 leaves N, Z and V unchanged; dst is still produced.
REQ-028 Flags never change on a stall edge.

Reset
REQ-029 When rst=1 at an edge, the following clear on that edge: out_valid=0, s1_valid=0, dst=0, N=0, Z=0, V=0. Any in-flight operations are discarded.
REQ-030 When rst=1, in_ready=0 combinationally, and no operation is accepted on that edge.
REQ-031 Reset has priority over every simultaneous input.

Configuration
REQ-032 Macro ALU_PIPE_SAT_EN, when defined, enables saturation: on add/sub overflow, dst is the maximum positive value (0x7FFF for WIDTH=16) if the true result is positive, or the minimum negative value (0x8000) if negative.
REQ-033 Without ALU_PIPE_SAT_EN, add/sub results wrap.
REQ-034 V is set on overflow in both builds, and N follows the delivered dst.

Structure
REQ-035 Package alu_pipe_pkg holds the opcode constants (OP_ADD through OP_LHB) and the flag-bundle typedef {N,Z,V}.
REQ-036 Combinational datapath in sub-module alu_pipe_core (op, operands, shamt -> result, overflow); alu_pipe holds the pipeline registers, handshake and flag registers.

Verification (WIDTH=16)
REQ-037 SAT build: add 0x7FFF+0x0001 gives dst=0x7FFF, V=1, N=0, Z=0, with out_valid one edge after acceptance. Wrap build: dst=0x8000, V=1, N=1.
REQ-038 SAT build: sub 0x8000-0x0001 gives dst=0x8000, V=1, N=1. Then sub 0x0005-0x0005 gives dst=0x0000, Z=1, V=0, N=0.
REQ-039 Hold out_ready=0 and issue three back-to-back ops:
  - Two are accepted, then in_ready=0.
  - Releasing out_ready delivers all three in order, one per cycle.
REQ-040 Shift and lhb sequence:
  - sra 0x8000, shamt=15 gives dst=0xFFFF, Z=0, N/V unchanged.
  - lhb src1=0x12AB, src0=0x34CD gives dst=0xABCD.
  - srl 0x8000, shamt=15 gives dst=0x0001.
REQ-041 Flag hold and mid-operation reset:
  - After Z=0, and 0x00F0&0x0F00 with flag_hold=1 gives dst=0x0000 and Z stays 0.
  - Asserting rst with two ops in flight gives out_valid=0 and N=Z=V=0 on the next edge, and no stale result appears after reset releases.
